// File: rtl/pipelined_ripple_adder.sv
// ---------------------------------------------------------------------------
// pipelined_ripple_adder
//
// Pipelined ripple-carry adder. The DATA_WIDTH-bit add is split into
// STAGES = DATA_WIDTH / CHUNK_WIDTH chunks. Each chunk is a plain ripple of
// CHUNK_WIDTH full-adder cells closed by a register. Operands, partial sums
// and the inter-chunk carry travel down the pipeline together with a valid
// bit. A single global advance enable stalls every stage at once, so results
// leave strictly in acceptance order.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous, active-high reset
//   a, b     in   DATA_WIDTH operands
//   ci       in   carry in
//   in_vld   in   operands valid
//   in_rd    out  operands accepted this cycle (combinational on out_rd, rst)
//   s        out  (a + b + ci) mod 2^DATA_WIDTH
//   co       out  unsigned carry out of bit DATA_WIDTH-1
//   ov       out  signed overflow (carry into MSB xor carry out of MSB)
//   out_vld  out  result valid (registered, independent of out_rd)
//   out_rd   in   downstream accepts result
// ---------------------------------------------------------------------------
module pipelined_ripple_adder #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  ci,
   input  logic                  in_vld,
   output logic                  in_rd,
   output logic [DATA_WIDTH-1:0] s,
   output logic                  co,
   output logic                  ov,
   output logic                  out_vld,
   input  logic                  out_rd
);

   localparam int STAGES = DATA_WIDTH / CHUNK_WIDTH;
   localparam int LAST   = STAGES - 1;

   if ((CHUNK_WIDTH < 1) || (CHUNK_WIDTH > DATA_WIDTH) ||
       (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_width_check
      $error("pipelined_ripple_adder: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
   end

   // Ripple of CHUNK_WIDTH full-adder cells.
   // Result layout: {carry into top cell, carry out of top cell, sum chunk}.
   function automatic logic [CHUNK_WIDTH+1:0] ripple_chunk(
      input logic [CHUNK_WIDTH-1:0] x,
      input logic [CHUNK_WIDTH-1:0] y,
      input logic                   cin
   );
      logic [CHUNK_WIDTH-1:0] sum;
      logic                   c;
      logic                   c_top;
      sum   = '0;
      c     = cin;
      c_top = cin;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         if (i == CHUNK_WIDTH - 1) c_top = c;
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c_top, c, sum};
   endfunction

   // Stage registers. Element k is the register closing stage k.
   logic [STAGES-1:0]     vld_q, vld_d;
   logic [STAGES-1:0]     cy_q, cy_d;
   logic [DATA_WIDTH-1:0] sum_q [STAGES];
   logic [DATA_WIDTH-1:0] sum_d [STAGES];
   logic [DATA_WIDTH-1:0] opa_q [STAGES];
   logic [DATA_WIDTH-1:0] opa_d [STAGES];
   logic [DATA_WIDTH-1:0] opb_q [STAGES];
   logic [DATA_WIDTH-1:0] opb_d [STAGES];
   // Carry into bit DATA_WIDTH-1; only the last stage owns the MSB.
   logic                  cmsb_q, cmsb_d;

   // Stage inputs: stage 0 reads the ports, stage k reads register k-1.
   logic [STAGES-1:0]     st_vld;
   logic [STAGES-1:0]     st_cin;
   logic [DATA_WIDTH-1:0] st_a   [STAGES];
   logic [DATA_WIDTH-1:0] st_b   [STAGES];
   logic [DATA_WIDTH-1:0] st_sum [STAGES];

   logic en;

   always_comb begin
      logic [CHUNK_WIDTH+1:0] r;

      // Global stall: everything advances or everything holds.
      en    = !vld_q[LAST] | out_rd;
      in_rd = en & !rst;

      st_vld[0] = in_vld & in_rd;
      st_cin[0] = ci;
      st_a[0]   = a;
      st_b[0]   = b;
      st_sum[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         st_vld[k] = vld_q[k-1];
         st_cin[k] = cy_q[k-1];
         st_a[k]   = opa_q[k-1];
         st_b[k]   = opb_q[k-1];
         st_sum[k] = sum_q[k-1];
      end

      vld_d  = vld_q;
      cy_d   = cy_q;
      cmsb_d = cmsb_q;
      sum_d  = sum_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      r      = '0;

      for (int k = 0; k < STAGES; k++) begin
         if (en) begin
            vld_d[k] = st_vld[k];
            // Bubbles only move the valid bit; data registers keep their
            // contents so the outputs hold while out_vld is low.
            if (st_vld[k]) begin
               r = ripple_chunk(st_a[k][k*CHUNK_WIDTH +: CHUNK_WIDTH],
                                st_b[k][k*CHUNK_WIDTH +: CHUNK_WIDTH],
                                st_cin[k]);
               sum_d[k] = st_sum[k];
               sum_d[k][k*CHUNK_WIDTH +: CHUNK_WIDTH] = r[CHUNK_WIDTH-1:0];
               cy_d[k]  = r[CHUNK_WIDTH];
               opa_d[k] = st_a[k];
               opb_d[k] = st_b[k];
               if (k == LAST) cmsb_d = r[CHUNK_WIDTH+1];
            end
         end
      end
   end

   // ---- stage register boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         cy_q   <= '0;
         cmsb_q <= 1'b0;
         sum_q  <= '{default: '0};
         opa_q  <= '{default: '0};
         opb_q  <= '{default: '0};
      end else begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         cmsb_q <= cmsb_d;
         sum_q  <= sum_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
      end
   end

   // Outputs are forced quiet while reset is held, including the cycle
   // before the synchronous clear takes effect.
   always_comb begin
      out_vld = vld_q[LAST] & !rst;
      s       = rst ? '0 : sum_q[LAST];
      co      = cy_q[LAST] & !rst;
      ov      = (cmsb_q ^ cy_q[LAST]) & !rst;
   end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
module tb_pipelined_ripple_adder;

   localparam int DW = 8;
   localparam int NST = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] a, b, s;
   logic          ci, in_vld, in_rd, co, ov, out_vld, out_rd;

   logic [DW-1:0] a1, b1, s1;
   logic          ci1, in_vld1, in_rd1, co1, ov1, out_vld1, out_rd1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [DW+1:0] exp_q[$];
   int            pop_log[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_ripple_adder #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .in_vld(in_vld),
      .in_rd(in_rd), .s(s), .co(co), .ov(ov), .out_vld(out_vld), .out_rd(out_rd)
   );

   pipelined_ripple_adder #(.DATA_WIDTH(8), .CHUNK_WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1), .in_vld(in_vld1),
      .in_rd(in_rd1), .s(s1), .co(co1), .ov(ov1), .out_vld(out_vld1), .out_rd(out_rd1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {ov, co, s}.
   function automatic logic [DW+1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic c);
      int unsigned u;
      int          sx, sy, sg;
      logic        o;
      u  = int'(x) + int'(y) + int'(c);
      sx = $signed(x);
      sy = $signed(y);
      sg = sx + sy + int'(c);
      o  = (sg > 127) || (sg < -128);
      return {o, u[8], u[7:0]};
   endfunction

   // Scoreboard and protocol monitor for the 4-stage instance.
   logic          stall_prev = 1'b0;
   logic [DW+1:0] held;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         chk("rst_out_vld", out_vld, 0);
         chk("rst_in_rd", in_rd, 0);
         chk("rst_outputs", {ov, co, s}, 0);
         stall_prev = 1'b0;
      end else begin
         chk("in_rd_rule", in_rd, (!out_vld) | out_rd);
         if (stall_prev) begin
            chk("stall_vld", out_vld, 1);
            chk("stall_hold", {ov, co, s}, held);
         end
         if (out_vld && out_rd) begin
            if (exp_q.size() == 0) chk("unexpected_result", exp_q.size(), 1);
            else chk("result", {ov, co, s}, exp_q.pop_front());
            pop_log.push_back(cyc);
         end
         if (in_vld && in_rd) exp_q.push_back(model(a, b, ci));
         stall_prev = out_vld && !out_rd;
         held       = {ov, co, s};
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] xa, input logic [DW-1:0] xb, input logic xc);
      int k = 0;
      bit done = 0;
      a = xa; b = xb; ci = xc; in_vld = 1'b1;
      while (!done && k < 40) begin
         @(negedge clk);
         done = in_rd;
         tick;
         k++;
      end
      chk("send_accepted", done, 1);
   endtask

   // Single transfer into an idle pipeline; checks exact latency and value.
   task automatic one_shot(input string name, input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                           input logic xc, input logic [DW-1:0] es, input logic eco,
                           input logic eov);
      a = xa; b = xb; ci = xc; in_vld = 1'b1;
      @(negedge clk);
      chk({name, "_in_rd"}, in_rd, 1);
      tick;
      in_vld = 1'b0;
      for (int i = 0; i < NST - 1; i++) begin
         @(negedge clk);
         chk({name, "_early"}, out_vld, 0);
      end
      @(negedge clk);
      chk({name, "_vld"}, out_vld, 1);
      chk({name, "_s"}, s, es);
      chk({name, "_co"}, co, eco);
      chk({name, "_ov"}, ov, eov);
      tick;
   endtask

   task automatic drain(input string name);
      int k = 0;
      in_vld = 1'b0;
      out_rd = 1'b1;
      while (exp_q.size() != 0 && k < 100) begin
         tick;
         k++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          ci;
      logic [DW-1:0] s;
      logic          co;
      logic          ov;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[7] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
      tbl[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
      tbl[9] = '{8'h81, 8'h80, 1'b1, 8'h02, 1'b1, 1'b1};

      rst = 1'b1; a = '0; b = '0; ci = 1'b0; in_vld = 1'b0; out_rd = 1'b1;
      a1 = '0; b1 = '0; ci1 = 1'b0; in_vld1 = 1'b0; out_rd1 = 1'b1;
      repeat (3) tick;
      rst = 1'b0;
      @(negedge clk);
      chk("in_rd_after_reset", in_rd, 1);
      chk("out_vld_after_reset", out_vld, 0);
      chk("stg1_out_vld_after_reset", out_vld1, 0);
      tick;

      // Directed vectors.
      for (int i = 0; i < 10; i++)
         one_shot($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci,
                  tbl[i].s, tbl[i].co, tbl[i].ov);
      tick;

      // 16 back-to-back random transfers: results must come out consecutively.
      pop_log.delete();
      for (int i = 0; i < 16; i++)
         send(DW'($urandom), DW'($urandom), 1'($urandom));
      in_vld = 1'b0;
      for (int k = 0; k < 50 && pop_log.size() < 16; k++) tick;
      chk("stream_count", pop_log.size(), 16);
      if (pop_log.size() == 16) chk("stream_consecutive", pop_log[15] - pop_log[0], 15);
      chk("stream_queue_empty", exp_q.size(), 0);

      // Backpressure: drop out_rd for 3 cycles mid-stream.
      pop_log.delete();
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(DW'($urandom), DW'($urandom), 1'($urandom));
            in_vld = 1'b0;
         end
         begin
            for (int k = 0; k < 40 && pop_log.size() < 2; k++) tick;
            out_rd = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_in_rd_low", in_rd, 0);
               chk("bp_out_vld", out_vld, 1);
               tick;
            end
            out_rd = 1'b1;
         end
      join
      for (int k = 0; k < 50 && pop_log.size() < 8; k++) tick;
      chk("bp_count", pop_log.size(), 8);
      drain("bp");

      // Reset with three transfers in flight.
      tick;
      send(8'h11, 8'h22, 1'b0);
      send(8'h33, 8'h44, 1'b1);
      send(8'hF0, 8'h0F, 1'b1);
      in_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_rd", in_rd, 0);
      chk("midrst_out_vld", out_vld, 0);
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_rd_after", in_rd, 1);
      for (int k = 0; k < 6; k++) begin
         tick;
         @(negedge clk);
         chk("midrst_no_stale", out_vld, 0);
      end
      tick;
      one_shot("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         in_vld = ($urandom_range(3) != 0);
         a      = DW'($urandom);
         b      = DW'($urandom);
         ci     = 1'($urandom);
         out_rd = ($urandom_range(2) != 0);
         tick;
      end
      drain("random");

      // Single-stage configuration.
      a1 = 8'hFF; b1 = 8'hFF; ci1 = 1'b1; in_vld1 = 1'b1;
      @(negedge clk);
      chk("stg1_in_rd", in_rd1, 1);
      chk("stg1_idle", out_vld1, 0);
      tick;
      in_vld1 = 1'b0;
      @(negedge clk);
      chk("stg1_vld", out_vld1, 1);
      chk("stg1_s", s1, 8'hFF);
      chk("stg1_co", co1, 1);
      chk("stg1_ov", ov1, 0);
      tick;
      @(negedge clk);
      chk("stg1_consumed", out_vld1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end

endmodule
